demux_1_to_2_16bit_buf: RTL and testbench

- Buffered 16-bit 1-to-2 demultiplexer: the inverse of the datapath 2-to-1 word select.
- Takes one word stream, with a per-word select bit, and steers each word into one of two per-destination FIFOs.
- Each FIFO drives its own valid/ready output channel.
- Sits between the processor result bus and its two consumers (channel 0: register-file write-back; channel 1: memory/IO write path). A stalled consumer blocks only its own channel while space remains.

---
 rtl/demux_1_to_2_16bit_buf.sv | 85 ++++++++
 tb/tb_demux_1_to_2_16bit_buf.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/demux_1_to_2_16bit_buf.sv
// Buffered 1-to-2 word demultiplexer: each input word is steered by S into one
// of two small FIFOs, and each FIFO drives its own valid/ready output channel.
module demux_1_to_2_16bit_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             S,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic [WIDTH-1:0] I,
  output logic             Q0_valid,
  input  logic             Q0_ready,
  output logic [WIDTH-1:0] Q0,
  output logic             Q1_valid,
  input  logic             Q1_ready,
  output logic [WIDTH-1:0] Q1,
  output logic [CW-1:0]    Count0,
  output logic [CW-1:0]    Count1
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem0 [DEPTH];
  logic [WIDTH-1:0] r_mem1 [DEPTH];
  logic [AW-1:0]    r_wptr0, r_rptr0, r_wptr1, r_rptr1;
  logic [CW-1:0]    r_count0, r_count1;

  logic w_accept, w_push0, w_push1, w_pop0, w_pop1;

  // A full channel still accepts when its consumer drains the head this cycle.
  assign I_ready  = ~Reset & (S ? ((r_count1 != FULL) | Q1_ready)
                                : ((r_count0 != FULL) | Q0_ready));
  assign w_accept = I_valid & I_ready;
  assign w_push0  = w_accept & ~S;
  assign w_push1  = w_accept & S;

  assign Q0_valid = (r_count0 != '0);
  assign Q1_valid = (r_count1 != '0);
  assign w_pop0   = Q0_valid & Q0_ready;
  assign w_pop1   = Q1_valid & Q1_ready;

  assign Q0     = Q0_valid ? r_mem0[r_rptr0] : '0;
  assign Q1     = Q1_valid ? r_mem1[r_rptr1] : '0;
  assign Count0 = r_count0;
  assign Count1 = r_count1;

  // Storage needs no reset: the counts alone decide which entries are live.
  always_ff @(posedge Clock) begin
    if (w_push0) r_mem0[r_wptr0] <= I;
    if (w_push1) r_mem1[r_wptr1] <= I;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wptr0  <= '0;
      r_rptr0  <= '0;
      r_wptr1  <= '0;
      r_rptr1  <= '0;
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      if (w_push0) r_wptr0 <= r_wptr0 + AW'(1);
      if (w_pop0)  r_rptr0 <= r_rptr0 + AW'(1);
      if (w_push1) r_wptr1 <= r_wptr1 + AW'(1);
      if (w_pop1)  r_rptr1 <= r_rptr1 + AW'(1);

      case ({w_push0, w_pop0})
        2'b10:   r_count0 <= r_count0 + CW'(1);
        2'b01:   r_count0 <= r_count0 - CW'(1);
        default: r_count0 <= r_count0;
      endcase

      case ({w_push1, w_pop1})
        2'b10:   r_count1 <= r_count1 + CW'(1);
        2'b01:   r_count1 <= r_count1 - CW'(1);
        default: r_count1 <= r_count1;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1_to_2_16bit_buf.sv
// Bench for demux_1_to_2_16bit_buf: directed steps plus a random phase, all
// checked against a queue-per-channel reference model.
module tb_demux_1_to_2_16bit_buf;

  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        S;
  logic        I_valid;
  logic        I_ready;
  logic [15:0] I;
  logic        Q0_valid, Q0_ready;
  logic [15:0] Q0;
  logic        Q1_valid, Q1_ready;
  logic [15:0] Q1;
  logic [1:0]  Count0, Count1;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          checks = 0;
  int          fails  = 0;
  bit          lastAccept;

  demux_1_to_2_16bit_buf #(.WIDTH(16), .DEPTH(DEPTH), .CW(2)) dut (
    .Clock(Clock), .Reset(Reset), .S(S), .I_valid(I_valid), .I_ready(I_ready), .I(I),
    .Q0_valid(Q0_valid), .Q0_ready(Q0_ready), .Q0(Q0),
    .Q1_valid(Q1_valid), .Q1_ready(Q1_ready), .Q1(Q1),
    .Count0(Count0), .Count1(Count1)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs come only from the queue model and the current inputs.
  task automatic checkOutput();
    bit expReady;
    expReady = S ? ((q1.size() != DEPTH) || Q1_ready) : ((q0.size() != DEPTH) || Q0_ready);
    check("i_ready",  I_ready,  expReady);
    check("q0_valid", Q0_valid, q0.size() != 0);
    check("q0_data",  Q0,       (q0.size() != 0) ? q0[0] : 16'h0000);
    check("count0",   Count0,   q0.size());
    check("q1_valid", Q1_valid, q1.size() != 0);
    check("q1_data",  Q1,       (q1.size() != 0) ? q1[0] : 16'h0000);
    check("count1",   Count1,   q1.size());
  endtask

  task automatic applyStimulus(input logic s, input logic iv, input logic [15:0] d,
                               input logic r0, input logic r1);
    bit acc, pop0, pop1;
    @(negedge Clock);
    S = s; I_valid = iv; I = d; Q0_ready = r0; Q1_ready = r1;
    #1 checkOutput();
    acc  = iv && (s ? ((q1.size() != DEPTH) || r1) : ((q0.size() != DEPTH) || r0));
    pop0 = (q0.size() != 0) && r0;
    pop1 = (q1.size() != 0) && r1;
    @(posedge Clock);
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    lastAccept = acc;
  endtask

  task automatic doReset();
    @(negedge Clock);
    Reset = 1'b1; I_valid = 1'b1; S = 1'b0; I = 16'(($urandom));
    Q0_ready = 1'b1; Q1_ready = 1'b1;
    #1 check("reset_i_ready", I_ready, 1'b0);
    @(posedge Clock);
    q0.delete();
    q1.delete();
    #1 Reset = 1'b0; I_valid = 1'b0;
  endtask

  initial begin
    logic        hs;
    logic [15:0] hd;
    bit          pending;
    int          k, cyc;

    Reset = 1'b1; S = 1'b0; I_valid = 1'b0; I = '0; Q0_ready = 1'b0; Q1_ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // Idle after reset, ready for both selects
    applyStimulus(0, 0, 16'h1234, 0, 0);
    applyStimulus(1, 0, 16'h1234, 0, 0);
    check("idle_count0", Count0, 2'd0);

    // Alternate steering, consumers ready
    applyStimulus(0, 1, 16'hA001, 1, 1);
    applyStimulus(1, 1, 16'hB002, 1, 1);
    applyStimulus(0, 0, 16'h0000, 1, 1);
    applyStimulus(0, 0, 16'h0000, 1, 1);

    // Fill channel 0, then backpressure, then steer to channel 1
    applyStimulus(0, 1, 16'h0011, 0, 0);
    applyStimulus(0, 1, 16'h0022, 0, 0);
    applyStimulus(0, 1, 16'h0099, 0, 0);
    check("fill_blocked", lastAccept, 1'b0);
    applyStimulus(1, 1, 16'h0099, 0, 0);

    // Full pass-through, then drain both channels
    applyStimulus(0, 1, 16'h0033, 1, 0);
    check("pass_accept", lastAccept, 1'b1);
    repeat (4) applyStimulus(0, 0, 16'h0000, 1, 1);

    // Wrap-around stream into channel 1 with toggling consumer
    k = 1; cyc = 0;
    while (k <= 8 && cyc < 60) begin
      applyStimulus(1, 1, 16'(k), 1, cyc[0]);
      if (lastAccept) k++;
      cyc++;
    end
    check("wrap_all_accepted", k, 9);
    repeat (3) applyStimulus(0, 0, 16'h0000, 1, 1);

    // Reset mid-operation
    applyStimulus(0, 1, 16'h0C01, 0, 0);
    applyStimulus(0, 1, 16'h0C02, 0, 0);
    applyStimulus(1, 1, 16'h0C03, 0, 0);
    check("pre_reset_count0", Count0, 2'd2);
    doReset();
    applyStimulus(1, 1, 16'hBEEF, 0, 0);
    applyStimulus(0, 0, 16'h0000, 0, 0);
    check("post_reset_q1", Q1, 16'hBEEF);

    // Randomized traffic, holding S/I while a word is stalled
    pending = 1'b0; hs = 1'b0; hd = '0;
    for (int n = 0; n < 300; n++) begin
      logic iv;
      iv = pending ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (!pending) begin
        hs = 1'($urandom);
        hd = 16'($urandom);
      end
      applyStimulus(hs, iv, hd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
      pending = iv && !lastAccept;
      if (n == 150) doReset();
      if (n == 150) pending = 1'b0;
    end
    repeat (4) applyStimulus(0, 0, 16'h0000, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
